// File: rtl/decode_if.sv
// decode_if: fetch-side handshake, writeback port and execute-side bundle of the decode stage.
interface decode_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 3,
   parameter int INS_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [INS_W-1:0]  ins;
   logic              wb_en;
   logic [REG_AW-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] r1;
   logic [DATA_W-1:0] r2;
   logic [REG_AW-1:0] rd;
   logic [1:0]        instruction_type;
   logic              illegal;
   modport master (
      output in_valid, ins, wb_en, wb_addr, wb_data, out_ready,
      input  in_ready, out_valid, r1, r2, rd, instruction_type, illegal
   );
   modport slave (
      input  in_valid, ins, wb_en, wb_addr, wb_data, out_ready,
      output in_ready, out_valid, r1, r2, rd, instruction_type, illegal
   );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: pipelined decode with register bank, writeback bypass and busy scoreboard.
module decode_stage #(
   parameter int DATA_W = 16,
   parameter int NREG   = 8,
   parameter int REG_AW = $clog2(NREG),
   parameter int INS_W  = 16
) (
   input logic     clk,
   input logic     rst_n,
   decode_if.slave bus
);
   logic [DATA_W-1:0] rf [NREG];
   logic [NREG-1:0]   busy, busy_n;
   logic [3:0]        opcode;
   logic [REG_AW-1:0] rd_f, rs1, rs2;
   logic [2:0]        func3;
   logic              reg_mode, stall, acc;
   logic [DATA_W-1:0] rd1, rd2;
   assign opcode   = bus.ins[3:0];
   assign rd_f     = bus.ins[4+:REG_AW];
   assign rs2      = bus.ins[4+REG_AW+:REG_AW];
   assign rs1      = bus.ins[4+2*REG_AW+:REG_AW];
   assign func3    = bus.ins[INS_W-1-:3];
   assign reg_mode = opcode == 4'b0001;
   // writeback in flight counts as already done for both reads and hazards
   assign rd1   = (bus.wb_en && bus.wb_addr == rs1) ? bus.wb_data : rf[rs1];
   assign rd2   = (bus.wb_en && bus.wb_addr == rs2) ? bus.wb_data : rf[rs2];
   assign stall = bus.in_valid &&
                  ((busy[rs2] && !(bus.wb_en && bus.wb_addr == rs2)) ||
                   (reg_mode && busy[rs1] && !(bus.wb_en && bus.wb_addr == rs1)));
   assign bus.in_ready = (!bus.out_valid || bus.out_ready) && !stall;
   assign acc = bus.in_valid && bus.in_ready;
   always_comb begin
      busy_n = busy;
      if (bus.wb_en) busy_n[bus.wb_addr] = 1'b0;
      if (acc && !func3[2]) busy_n[rd_f] = 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) rf[i] <= DATA_W'(i + 1);
         busy                 <= '0;
         bus.out_valid        <= 1'b0;
         bus.r1               <= '0;
         bus.r2               <= '0;
         bus.rd               <= '0;
         bus.instruction_type <= '0;
         bus.illegal          <= 1'b0;
      end else begin
         if (bus.wb_en) rf[bus.wb_addr] <= bus.wb_data;
         busy <= busy_n;
         if (acc) begin
            bus.out_valid        <= 1'b1;
            bus.r1               <= reg_mode ? rd1 : DATA_W'(rs1);
            bus.r2               <= rd2;
            bus.rd               <= rd_f;
            bus.instruction_type <= func3[2] ? 2'd0 : func3[1:0];
            bus.illegal          <= func3[2];
         end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed vectors with hand-computed expectations for decode_stage.
module tb_decode_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;
   decode_if #(.DATA_W(16), .REG_AW(3), .INS_W(16)) bus ();
   decode_stage #(.DATA_W(16), .NREG(8), .REG_AW(3), .INS_W(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] mk(input int f3, input int s1, input int s2, input int d, input int op);
      return {f3[2:0], s1[2:0], s2[2:0], d[2:0], op[3:0]};
   endfunction
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      bus.in_valid = 0;
      bus.ins = '0;
      bus.wb_en = 0;
      bus.wb_addr = '0;
      bus.wb_data = '0;
      bus.out_ready = 1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      #1;
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_r1", bus.r1, 0);
      chk("rst_r2", bus.r2, 0);
      chk("rst_rd", bus.rd, 0);
      chk("rst_type", bus.instruction_type, 0);
      chk("rst_illegal", bus.illegal, 0);
      chk("rst_in_ready", bus.in_ready, 1);
      // register mode: r1=reg2=3, r2=reg3=4
      bus.ins = mk(1, 2, 3, 5, 1);
      bus.in_valid = 1;
      #1 chk("t1_in_ready", bus.in_ready, 1);
      step();
      chk("t1_out_valid", bus.out_valid, 1);
      chk("t1_r1", bus.r1, 3);
      chk("t1_r2", bus.r2, 4);
      chk("t1_rd", bus.rd, 5);
      chk("t1_type", bus.instruction_type, 1);
      chk("t1_illegal", bus.illegal, 0);
      // immediate mode
      bus.ins = mk(0, 6, 2, 1, 0);
      step();
      chk("imm_r1", bus.r1, 6);
      chk("imm_r2", bus.r2, 3);
      chk("imm_rd", bus.rd, 1);
      chk("imm_type", bus.instruction_type, 0);
      // busy rs1 only stalls in register mode (busy: 5,1)
      bus.ins = mk(0, 5, 0, 0, 0);
      #1 chk("imm_busy_rs1_ready", bus.in_ready, 1);
      bus.ins = mk(0, 5, 0, 0, 1);
      #1 chk("reg_busy_rs1_stall", bus.in_ready, 0);
      // hazard on rs2 resolved by bypassed writeback
      bus.ins = mk(2, 0, 0, 4, 0);
      step();
      chk("w4_r2", bus.r2, 1);
      chk("w4_type", bus.instruction_type, 2);
      bus.ins = mk(3, 0, 4, 6, 0);
      #1 chk("haz_stall", bus.in_ready, 0);
      step();
      chk("haz_out_drop", bus.out_valid, 0);
      chk("haz_still_stall", bus.in_ready, 0);
      bus.wb_en = 1;
      bus.wb_addr = 3'd4;
      bus.wb_data = 16'h1234;
      #1 chk("haz_bypass_ready", bus.in_ready, 1);
      step();
      bus.wb_en = 0;
      chk("haz_out_valid", bus.out_valid, 1);
      chk("haz_r2", bus.r2, 16'h1234);
      chk("haz_rd", bus.rd, 6);
      chk("haz_type", bus.instruction_type, 3);
      // backpressure with a pending instruction
      bus.ins = mk(0, 3, 0, 2, 0);
      step();
      chk("bp_a_r1", bus.r1, 3);
      bus.ins = mk(0, 7, 0, 3, 0);
      bus.out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("bp_in_ready", bus.in_ready, 0);
         step();
         chk("bp_hold_valid", bus.out_valid, 1);
         chk("bp_hold_r1", bus.r1, 3);
         chk("bp_hold_rd", bus.rd, 2);
      end
      bus.out_ready = 1;
      #1 chk("bp_release_ready", bus.in_ready, 1);
      step();
      chk("bp_b_r1", bus.r1, 7);
      chk("bp_b_rd", bus.rd, 3);
      bus.in_valid = 0;
      step();
      chk("bp_drain", bus.out_valid, 0);
      // illegal func3 sets no busy bit
      bus.in_valid = 1;
      bus.ins = mk(5, 0, 0, 7, 0);
      step();
      chk("ill_flag", bus.illegal, 1);
      chk("ill_type", bus.instruction_type, 0);
      chk("ill_rd", bus.rd, 7);
      bus.ins = mk(0, 0, 7, 0, 0);
      #1 chk("ill_no_busy", bus.in_ready, 1);
      step();
      chk("ill_next_r2", bus.r2, 8);
      chk("ill_next_illegal", bus.illegal, 0);
      // asynchronous reset during backpressure
      bus.ins = mk(0, 1, 0, 2, 0);
      bus.out_ready = 0;
      step();
      chk("mr_pre_valid", bus.out_valid, 1);
      #3 rst_n = 0;
      #1 chk("mr_async_valid", bus.out_valid, 0);
      chk("mr_async_r1", bus.r1, 0);
      bus.in_valid = 0;
      bus.out_ready = 1;
      step();
      rst_n = 1;
      bus.in_valid = 1;
      bus.ins = mk(1, 5, 1, 7, 1);
      #1 chk("mr_busy_cleared", bus.in_ready, 1);
      step();
      chk("mr_r1", bus.r1, 6);
      chk("mr_r2", bus.r2, 2);
      bus.ins = mk(0, 4, 0, 2, 1);
      step();
      chk("mr_reg4_reset", bus.r1, 5);
      chk("mr_reg0_reset", bus.r2, 1);
      bus.in_valid = 0;
      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
